sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin arbiter in front of a single-port
// SRAM controller. Requester 0 is the data side, requester 1 the fetch side.
// Optional feature: define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC
// cycles and pulse timeout_err together with the granted ready.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_r_en,
  input  logic [1:0]  req_w_en,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [63:0] req_rdata,
  output logic [1:0]  req_ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_freeze
`ifdef ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  // Reject out-of-range timeout values at elaboration.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("sram_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  state_t      r_state;
  logic        r_rr;
  logic        r_gnt;
  logic        r_wr;
  logic [1:0]  w_pend;
  logic        w_idx;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TO = 8'(TIMEOUT_CYC);
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  assign w_cnt_nxt = r_cnt + 8'd1;
`endif

  // Grant selection: round-robin pointer only matters when both are pending.
  always_comb begin
    w_pend  = req_r_en | req_w_en;
    w_idx   = (&w_pend) ? r_rr : w_pend[1];
    w_wr    = req_w_en[w_idx];
    w_addr  = w_idx ? req_addr[63:32]  : req_addr[31:0];
    w_wdata = w_idx ? req_wdata[63:32] : req_wdata[31:0];
  end

  // Arbitration FSM with registered SRAM-side and requester-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      req_ready  <= '0;
      req_rdata  <= '0;
      sram_r_en  <= 1'b0;
      sram_w_en  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|w_pend) begin
            r_gnt      <= w_idx;
            r_wr       <= w_wr;
            sram_addr  <= w_addr;
            sram_wdata <= w_wdata;
            sram_w_en  <= w_wr;
            sram_r_en  <= ~w_wr;
            if (&w_pend) r_rr <= ~r_rr;
`ifdef ARB_TIMEOUT_EN
            r_cnt <= '0;
`endif
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!sram_freeze) begin
            sram_r_en        <= 1'b0;
            sram_w_en        <= 1'b0;
            req_ready[r_gnt] <= 1'b1;
            if (!r_wr) req_rdata <= sram_rdata;
            r_state <= ST_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_cnt_nxt == LP_TO) begin
            sram_r_en        <= 1'b0;
            sram_w_en        <= 1'b0;
            req_ready[r_gnt] <= 1'b1;
            timeout_err      <= 1'b1;
            r_state          <= ST_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed, table-driven bench for sram_arbiter.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_r_en;
  logic [1:0]  req_w_en;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] req_rdata;
  logic [1:0]  req_ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_freeze;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

`ifdef ARB_TIMEOUT_EN
  sram_arbiter #(.TIMEOUT_CYC(4)) dut (
`else
  sram_arbiter dut (
`endif
    .clk(clk), .rst(rst),
    .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ready(req_ready),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_freeze(sram_freeze)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  r_en;
    logic [1:0]  w_en;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        freeze;
    logic [63:0] srd;
    logic [1:0]  e_ready;
    logic        e_ren;
    logic        e_wen;
    logic [63:0] e_rdata;
    logic        chk_bus;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_r_en    = '0;
    req_w_en    = '0;
    req_addr    = '0;
    req_wdata   = '0;
    sram_rdata  = '0;
    sram_freeze = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // One-cycle transaction vectors: inputs for the cycle, outputs after its edge.
    tbl[0]  = '{2'b01, 2'b00, 64'h100, 64'h0, 1'b1, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 32'h100, 32'h0};
    tbl[1]  = '{2'b01, 2'b00, 64'h100, 64'h0, 1'b1, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 32'h100, 32'h0};
    tbl[2]  = '{2'b01, 2'b00, 64'h100, 64'h0, 1'b1, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 32'h100, 32'h0};
    tbl[3]  = '{2'b01, 2'b00, 64'h100, 64'h0, 1'b1, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 32'h100, 32'h0};
    tbl[4]  = '{2'b01, 2'b00, 64'h100, 64'h0, 1'b0, 64'h1122334455667788, 2'b01, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{2'b10, 2'b10, 64'h00000020_00000000, 64'hDEADBEEF_00000000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 1'b1, 64'h1122334455667788, 1'b1, 32'h20, 32'hDEADBEEF};
    tbl[7]  = '{2'b10, 2'b10, 64'h00000020_00000000, 64'hDEADBEEF_00000000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2'b10, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{2'b10, 2'b00, 64'h00000044_00000999, 64'h0, 1'b0, 64'hA5A5A5A5A5A5A5A5, 2'b00, 1'b1, 1'b0, 64'h1122334455667788, 1'b1, 32'h44, 32'h0};
    tbl[10] = '{2'b10, 2'b00, 64'h00000044_00000999, 64'h0, 1'b0, 64'h0102030405060708, 2'b10, 1'b0, 1'b0, 64'h0102030405060708, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0, 64'h0102030405060708, 1'b0, 32'h0, 32'h0};
    tbl[12] = '{2'b00, 2'b01, 64'h8, 64'hAAAAAAAA_12345678, 1'b0, 64'h0, 2'b00, 1'b0, 1'b1, 64'h0102030405060708, 1'b1, 32'h8, 32'h12345678};
    tbl[13] = '{2'b00, 2'b01, 64'h8, 64'hAAAAAAAA_12345678, 1'b0, 64'h5555555555555555, 2'b01, 1'b0, 1'b0, 64'h0102030405060708, 1'b0, 32'h0, 32'h0};
    tbl[14] = '{2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0, 64'h0102030405060708, 1'b0, 32'h0, 32'h0};

    // Reset state
    tick();
    chk("rst ready", 64'(req_ready), 64'h0);
    chk("rst rdata", req_rdata, 64'h0);
    chk("rst r_en", 64'(sram_r_en), 64'h0);
    chk("rst w_en", 64'(sram_w_en), 64'h0);
    chk("rst addr", 64'(sram_addr), 64'h0);
    chk("rst wdata", 64'(sram_wdata), 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Table: single read, forced write, fetch-side read, data-side write
    for (int i = 0; i < 15; i++) begin
      req_r_en    = tbl[i].r_en;
      req_w_en    = tbl[i].w_en;
      req_addr    = tbl[i].addr;
      req_wdata   = tbl[i].wdata;
      sram_freeze = tbl[i].freeze;
      sram_rdata  = tbl[i].srd;
      tick();
      chk($sformatf("row%0d ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
      chk($sformatf("row%0d r_en", i), 64'(sram_r_en), 64'(tbl[i].e_ren));
      chk($sformatf("row%0d w_en", i), 64'(sram_w_en), 64'(tbl[i].e_wen));
      chk($sformatf("row%0d rdata", i), req_rdata, tbl[i].e_rdata);
      if (tbl[i].chk_bus) begin
        chk($sformatf("row%0d addr", i), 64'(sram_addr), 64'(tbl[i].e_addr));
        chk($sformatf("row%0d wdata", i), 64'(sram_wdata), 64'(tbl[i].e_wdata));
      end
    end

    // Collision: both continuously pending from reset -> 0,1,0,1
    rst = 1'b0;
    idle_inputs();
    req_r_en    = 2'b11;
    req_addr    = 64'h00002000_00001000;
    sram_freeze = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("coll%0d r_en", k), 64'(sram_r_en), 64'h1);
      chk($sformatf("coll%0d addr", k), 64'(sram_addr), (k % 2 == 1) ? 64'h2000 : 64'h1000);
      tick();
      chk($sformatf("coll%0d ready", k), 64'(req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
      tick();
      chk($sformatf("coll%0d idle", k), 64'(req_ready), 64'h0);
    end

    // Reset in the 2nd BUSY cycle of a collision grant (which moved rr to 1)
    rst = 1'b0;
    idle_inputs();
    req_r_en = 2'b11;
    req_addr = 64'h00002000_00001000;
    tick();
    rst = 1'b1;
    tick();
    chk("ab grant addr", 64'(sram_addr), 64'h1000);
    tick();
    chk("ab busy2 r_en", 64'(sram_r_en), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("ab async r_en", 64'(sram_r_en), 64'h0);
    chk("ab async w_en", 64'(sram_w_en), 64'h0);
    tick();
    chk("ab ready", 64'(req_ready), 64'h0);
    sram_freeze = 1'b0;
    rst = 1'b1;
    tick();
    chk("ab rr regrant", 64'(sram_addr), 64'h1000);
    tick();
    chk("ab ready after", 64'(req_ready), 64'h1);
    req_r_en = 2'b00;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Timeout: freeze stuck high, TIMEOUT_CYC=4
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    req_r_en    = 2'b01;
    req_addr    = 64'h300;
    sram_freeze = 1'b1;
    sram_rdata  = 64'hFEEDFACECAFEBEEF;
    tick();
    chk("to grant", 64'(sram_r_en), 64'h1);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk($sformatf("to busy%0d ready", j), 64'(req_ready), 64'h0);
      chk($sformatf("to busy%0d err", j), 64'(timeout_err), 64'h0);
    end
    tick();
    chk("to ready", 64'(req_ready), 64'h1);
    chk("to err", 64'(timeout_err), 64'h1);
    chk("to rdata", req_rdata, 64'h0);
    chk("to r_en", 64'(sram_r_en), 64'h0);
    req_r_en = 2'b00;
    tick();
    chk("to idle ready", 64'(req_ready), 64'h0);
    chk("to idle err", 64'(timeout_err), 64'h0);
    req_r_en    = 2'b01;
    sram_freeze = 1'b0;
    tick();
    chk("to regrant", 64'(sram_r_en), 64'h1);
    tick();
    chk("to normal ready", 64'(req_ready), 64'h1);
    chk("to normal err", 64'(timeout_err), 64'h0);
    req_r_en = 2'b00;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
